// File: rtl/onehot_encoder_seq.sv
// Sequential 8-to-3 one-hot encoder: accepts one line word per handshake, scans it
// one bit per clock and reports the lowest set index plus a not-exactly-one-hot flag.
module onehot_encoder_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_lines,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] out_code,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       clr_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  shadow_q;
    logic [2:0]  idx_q;
    logic [1:0]  hits_q;
    logic [1:0]  hits_d;
    logic [2:0]  code_q;
    logic [2:0]  code_d;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [2:0]  out_code_q;
    logic        out_err_q;
    logic [7:0]  err_count_q;
    logic [7:0]  err_count_d;
    logic        bit_s;
    logic        last_s;
    logic        scan_err_s;

    // Scan step: hit count saturates at 2 so "more than one" stays distinguishable
    always_comb begin
        bit_s  = shadow_q[idx_q];
        hits_d = hits_q;
        code_d = code_q;
        if (bit_s) begin
            if (hits_q != 2'd2) begin
                hits_d = hits_q + 2'd1;
            end else begin
                hits_d = hits_q;
            end
            if (hits_q == 2'd0) begin
                code_d = idx_q;
            end else begin
                code_d = code_q;
            end
        end else begin
            hits_d = hits_q;
            code_d = code_q;
        end
        scan_err_s = (hits_d != 2'd1);
        last_s     = (state_q == SCAN) && (idx_q == 3'd7);
    end

    // Error counter next value; a clear beats a simultaneous increment
    always_comb begin
        err_count_d = err_count_q;
        if (clr_err) begin
            err_count_d = 8'd0;
        end else if (last_s && scan_err_s && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shadow_q    <= 8'd0;
            idx_q       <= 3'd0;
            hits_q      <= 2'd0;
            code_q      <= 3'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_code_q  <= 3'd0;
            out_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid) begin
                        shadow_q   <= in_lines;
                        idx_q      <= 3'd0;
                        hits_q     <= 2'd0;
                        code_q     <= 3'd0;
                        in_ready_q <= 1'b0;
                        state_q    <= SCAN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SCAN: begin
                    hits_q <= hits_d;
                    code_q <= code_d;
                    idx_q  <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        out_valid_q <= 1'b1;
                        out_code_q  <= code_d;
                        out_err_q   <= scan_err_s;
                        state_q     <= DONE;
                    end else begin
                        state_q <= SCAN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Self-checking bench for onehot_encoder_seq: directed plan plus random words
// against a lowest-set-bit / popcount reference model.
module tb_onehot_encoder_seq;

    logic       clk;
    logic       rst;
    logic [7:0] in_lines;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out_code;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       clr_err;
    logic [7:0] err_count;

    int n_tests   = 0;
    int n_fail    = 0;
    int exp_cnt   = 0;
    int cyc       = 0;
    int last_res  = -1;
    int excl_viol = 0;

    onehot_encoder_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_lines  (in_lines),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_code  (out_code),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr_err   (clr_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // in_ready and out_valid must never be high together
    always @(negedge clk) begin
        if (!rst && in_ready === 1'b1 && out_valid === 1'b1) excl_viol <= excl_viol + 1;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_code(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            if (w[i]) return i;
        end
        return 0;
    endfunction

    function automatic int ref_err(input logic [7:0] w);
        return ($countones(w) != 1) ? 1 : 0;
    endfunction

    // One full transaction: accept, scan, check result, optional stall, handshake
    task automatic do_word(input logic [7:0] w, input int stall, input bit clr_on, input bit chk_time);
        int n;
        int lat;
        int bad;
        int ec;
        int ee;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("in_ready_wait", in_ready, 1);
        in_lines  = w;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        check_val("busy_after_accept", in_ready, 0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            in_valid = 1'($urandom);
            in_lines = 8'($urandom);
            @(negedge clk);
            lat++;
            clr_err = clr_on && (lat == 7);
        end
        in_valid = 1'b0;
        clr_err  = 1'b0;
        check_val("out_valid_seen", out_valid, 1);
        if (chk_time) begin
            check_val("latency", lat, 8);
            if (last_res >= 0) check_val("spacing", cyc - last_res, 10);
            last_res = cyc;
        end
        ec = ref_code(w);
        ee = ref_err(w);
        if (clr_on) exp_cnt = 0;
        else if (ee == 1) exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
        check_val("code", out_code, ec);
        check_val("err", out_err, ee);
        check_val("err_count", err_count, exp_cnt);
        bad = 0;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            in_lines = 8'($urandom);
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_code !== 3'(ec) ||
                out_err !== 1'(ee) || err_count !== 8'(exp_cnt)) bad++;
        end
        if (stall > 0) check_val("stall_hold", bad, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("valid_drop", out_valid, 0);
        check_val("ready_back", in_ready, 1);
    endtask

    initial begin
        int seen;
        logic [7:0] w;
        rst = 1'b0; in_lines = 8'd0; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
        #3 rst = 1'b1;
        #1;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_code", out_code, 0);
        check_val("rst_out_err", out_err, 0);
        check_val("rst_err_count", err_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        last_res = -1;
        for (int i = 0; i < 8; i++) do_word(8'd1 << i, 0, 1'b0, 1'b1);
        check_val("sweep_err_count", err_count, 0);

        do_word(8'h00, 0, 1'b0, 1'b0);
        do_word(8'h28, 0, 1'b0, 1'b0);
        do_word(8'hFF, 0, 1'b0, 1'b0);
        check_val("err_count_3", err_count, 3);

        do_word(8'h40, 20, 1'b0, 1'b0);

        // Reset in the middle of scanning 8'h10
        in_lines = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("midrst_in_ready", in_ready, 1);
        check_val("midrst_err_count", err_count, 0);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check_val("midrst_no_result", seen, 0);
        check_val("midrst_ready_after", in_ready, 1);
        do_word(8'h02, 0, 1'b0, 1'b0);

        for (int i = 0; i < 260; i++) do_word(8'h00, 0, 1'b0, 1'b0);
        check_val("saturated", err_count, 255);
        do_word(8'h00, 0, 1'b1, 1'b0);
        check_val("cleared", err_count, 0);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(1, 0) == 1) w = 8'd1 << $urandom_range(7, 0);
            else w = 8'($urandom);
            do_word(w, $urandom_range(4, 0), 1'b0, 1'b0);
        end

        check_val("excl_ready_valid", excl_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
